// File: rtl/lcd_seq_counter.sv
// lcd_seq_counter: ROM address sequencer for LCD init/refresh tables.
// One-shot or looping walk from 0 to last_addr, stepped by tick.
module lcd_seq_counter #(
  parameter int N          = 3,
  parameter int AUTO_START = 1,
  parameter int LW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [N-1:0]  last_addr,
  output logic [N-1:0]  addr,
  output logic          busy,
  output logic          done,
  output logic          seq_end,
  output logic [LW-1:0] loop_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam state_t RST_ST = (AUTO_START != 0) ? RUN : IDLE;
  state_t        r_state, w_state_nx;
  logic [N-1:0]  r_addr, w_addr_nx;
  logic [LW-1:0] r_loop, w_loop_nx;
  logic          r_end, w_end_nx, w_term;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_ST;
      r_addr  <= '0;
      r_loop  <= '0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_loop  <= w_loop_nx;
      r_end   <= w_end_nx;
    end
  end
  // >= rather than == so a last_addr lowered below addr terminates instead of overrunning
  assign w_term = r_addr >= last_addr;
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_loop_nx  = r_loop;
    w_end_nx   = 1'b0;
    if (abort) begin
      w_state_nx = IDLE;
    end else if (start) begin
      w_state_nx = RUN;
      w_addr_nx  = '0;
      w_loop_nx  = '0;
    end else if (r_state == RUN && tick) begin
      w_end_nx   = w_term;
      w_addr_nx  = !w_term ? r_addr + 1'b1 : mode ? '0 : r_addr;
      w_state_nx = (w_term && !mode) ? DONE : RUN;
      w_loop_nx  = (w_term && mode && !(&r_loop)) ? r_loop + 1'b1 : r_loop;
    end
  end
  assign addr     = r_addr;
  assign loop_cnt = r_loop;
  assign seq_end  = r_end;
  assign busy     = r_state == RUN;
  assign done     = r_state == DONE;
endmodule

// File: tb/tb_lcd_seq_counter.sv
// tb_lcd_seq_counter: table-driven scoreboard bench for the default config,
// plus hand sequences on an LW=2, AUTO_START=0 instance sharing the inputs.
module tb_lcd_seq_counter;
  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [2:0] last_addr = 3'd0;
  logic [2:0] addr, addr2;
  logic       busy, done, seq_end, busy2, done2, seq_end2;
  logic [3:0] loop_cnt;
  logic [1:0] loop_cnt2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lcd_seq_counter dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort), .mode(mode),
    .last_addr(last_addr), .addr(addr), .busy(busy), .done(done), .seq_end(seq_end),
    .loop_cnt(loop_cnt)
  );

  lcd_seq_counter #(.N(3), .AUTO_START(0), .LW(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort), .mode(mode),
    .last_addr(last_addr), .addr(addr2), .busy(busy2), .done(done2), .seq_end(seq_end2),
    .loop_cnt(loop_cnt2)
  );

  typedef struct {int s, a, t, m, la, ea, eb, ed, ee, el;} vec_t;
  typedef struct {int ad, b, d, e, l;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int s, a, t, m, la, ea, eb, ed, ee, el);
    tbl.push_back('{s, a, t, m, la, ea, eb, ed, ee, el});
  endtask

  task automatic drive(input int s, a, t, m, la);
    start = (s != 0); abort = (a != 0); tick = (t != 0); mode = (m != 0); last_addr = 3'(la);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // boot one-shot, last=4
    add(0,0,1,0,4, 1,1,0,0,0); add(0,0,1,0,4, 2,1,0,0,0); add(0,0,1,0,4, 3,1,0,0,0);
    add(0,0,1,0,4, 4,1,0,0,0); add(0,0,1,0,4, 4,0,1,1,0); add(0,0,1,0,4, 4,0,1,0,0);
    add(0,0,1,0,4, 4,0,1,0,0);
    // restart, loop mode last=2, 9 ticks
    add(1,0,0,1,2, 0,1,0,0,0);
    add(0,0,1,1,2, 1,1,0,0,0); add(0,0,1,1,2, 2,1,0,0,0); add(0,0,1,1,2, 0,1,0,1,1);
    add(0,0,1,1,2, 1,1,0,0,1); add(0,0,1,1,2, 2,1,0,0,1); add(0,0,1,1,2, 0,1,0,1,2);
    add(0,0,1,1,2, 1,1,0,0,2); add(0,0,1,1,2, 2,1,0,0,2); add(0,0,1,1,2, 0,1,0,1,3);
    add(0,0,0,1,2, 0,1,0,0,3);
    // start/abort priority at addr=3
    add(0,0,1,0,6, 1,1,0,0,3); add(0,0,1,0,6, 2,1,0,0,3); add(0,0,1,0,6, 3,1,0,0,3);
    add(1,0,1,0,6, 0,1,0,0,0);
    add(0,0,1,0,6, 1,1,0,0,0); add(0,0,1,0,6, 2,1,0,0,0); add(0,0,1,0,6, 3,1,0,0,0);
    add(1,1,1,0,6, 3,0,0,0,0); add(0,0,1,0,6, 3,0,0,0,0); add(1,0,0,0,6, 0,1,0,0,0);
    // last_addr lowered under addr=4
    add(0,0,1,0,6, 1,1,0,0,0); add(0,0,1,0,6, 2,1,0,0,0); add(0,0,1,0,6, 3,1,0,0,0);
    add(0,0,1,0,6, 4,1,0,0,0); add(0,0,1,0,1, 4,0,1,1,0); add(0,0,1,0,1, 4,0,1,0,0);
    add(1,0,0,0,6, 0,1,0,0,0);
    add(0,0,1,0,6, 1,1,0,0,0); add(0,0,1,0,6, 2,1,0,0,0); add(0,0,1,0,6, 3,1,0,0,0);
    add(0,0,1,0,6, 4,1,0,0,0); add(0,0,1,1,1, 0,1,0,1,1); add(0,0,1,1,1, 1,1,0,0,1);

    #12;
    chk("rst_addr", 32'(addr), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_seq_end", 32'(seq_end), 0);
    chk("rst_loop", 32'(loop_cnt), 0);
    chk("rst_busy2", 32'(busy2), 0);
    drive(0,0,1,0,4);
    rst = 1'b0;
    foreach (tbl[i]) begin
      exp_t e;
      drive(tbl[i].s, tbl[i].a, tbl[i].t, tbl[i].m, tbl[i].la);
      sb.push_back('{tbl[i].ea, tbl[i].eb, tbl[i].ed, tbl[i].ee, tbl[i].el});
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_addr", i), 32'(addr), e.ad);
      chk($sformatf("v%0d_busy", i), 32'(busy), e.b);
      chk($sformatf("v%0d_done", i), 32'(done), e.d);
      chk($sformatf("v%0d_seq_end", i), 32'(seq_end), e.e);
      chk($sformatf("v%0d_loop", i), 32'(loop_cnt), e.l);
    end

    // AUTO_START=0 instance idles, then LW=2 saturation with continuous seq_end
    drive(0,0,0,0,0);
    rst = 1'b1; #2; rst = 1'b0;
    chk("idle2_busy", 32'(busy2), 0);
    drive(0,0,1,1,0); step();
    chk("idle2_tick_busy", 32'(busy2), 0);
    chk("idle2_tick_addr", 32'(addr2), 0);
    drive(1,0,1,1,0); step();
    chk("start2_busy", 32'(busy2), 1);
    for (int i = 0; i < 6; i++) begin
      drive(0,0,1,1,0); step();
      chk($sformatf("sat%0d_seq_end2", i), 32'(seq_end2), 1);
      chk($sformatf("sat%0d_loop2", i), 32'(loop_cnt2), (i < 2) ? i + 1 : 3);
      chk($sformatf("sat%0d_addr2", i), 32'(addr2), 0);
      chk($sformatf("sat%0d_loop", i), 32'(loop_cnt), i + 1);
    end
    drive(0,0,0,1,0); step();
    chk("sat_end_seq_end2", 32'(seq_end2), 0);
    chk("sat_end_loop2", 32'(loop_cnt2), 3);

    // async reset between edges at addr=2
    drive(1,0,0,0,6); step();
    drive(0,0,1,0,6); step(); step();
    chk("pre_arst_addr", 32'(addr), 2);
    drive(0,0,0,0,6);
    #2; rst = 1'b1; #1;
    chk("arst_addr", 32'(addr), 0);
    chk("arst_addr2", 32'(addr2), 0);
    chk("arst_busy", 32'(busy), 1);
    chk("arst_busy2", 32'(busy2), 0);
    chk("arst_loop", 32'(loop_cnt), 0);
    @(posedge clk); #3; rst = 1'b0;
    drive(0,0,1,0,6); step();
    chk("post_arst_addr", 32'(addr), 1);
    chk("post_arst_addr2", 32'(addr2), 0);
    chk("post_arst_busy2", 32'(busy2), 0);
    drive(1,0,1,0,6); step();
    chk("restart2_busy", 32'(busy2), 1);
    chk("restart2_addr", 32'(addr2), 0);
    drive(0,0,1,0,6); step();
    chk("run2_addr", 32'(addr2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_seq_counter.md
LCD_SEQ_COUNTER -- requirements
Module: lcd_seq_counter

Interface
REQ-001 Parameter N, default 3: address width in bits; legal range 1..16.
REQ-002 Parameter AUTO_START, default 1: 1 = enter RUN on reset release with no start pulse (boot sequence); 0 = wait in IDLE.
REQ-003 Parameter LW, default 4: width of loop_cnt in bits.
REQ-004 clk  input  1  single clock (divided clock or system clock); all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick  input  1  step enable; address advances only on cycles with tick=1.
REQ-007 start  input  1  one-cycle request: (re)start the sequence from address 0.
REQ-008 abort  input  1  one-cycle request: stop the sequence and go to IDLE.
REQ-009 mode  input  1  0 = one-shot (saturate at terminal); 1 = loop (wrap to 0); sampled on every tick.
REQ-010 last_addr  input  N  terminal address, inclusive; sampled on every tick.
REQ-011 addr  output  N  current address, registered; drives the ROM address.
REQ-012 busy  output  1  1 while in RUN.
REQ-013 done  output  1  level; 1 while in DONE.
REQ-014 seq_end  output  1  one-cycle pulse when a tick is consumed at the terminal address.
REQ-015 loop_cnt  output  LW  completed loops since the last start; saturates at all-ones.

Function
REQ-016 States: IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE); all outputs registered or decoded from state only.
REQ-017 Input priority each cycle: abort > start > tick.
REQ-018 abort, any state: next state IDLE; addr holds; loop_cnt holds; seq_end=0.
REQ-019 start (no abort), any state including mid-RUN: next state RUN, addr<=0, loop_cnt<=0, seq_end=0; a coincident tick is ignored.
REQ-020 IDLE with tick only: no change.
REQ-021 RUN, tick=1, addr < last_addr: addr<=addr+1.
REQ-022 RUN, tick=1, addr >= last_addr: terminal; seq_end=1 next cycle.
- mode=0: state DONE; addr holds its current value.
- mode=1: addr<=0; state stays RUN; loop_cnt<=loop_cnt+1, saturating.
REQ-023 Terminal comparison is unsigned >=, so lowering last_addr below addr mid-run ends or wraps on the next tick, with no overrun to 2^N-1.
REQ-024 last_addr=0: every tick in RUN is terminal; one-shot completes in one tick.
REQ-025 last_addr=2^N-1 with mode=1: wraps to 0 after all 2^N addresses; no arithmetic overflow path.
REQ-026 DONE with tick only: addr, done and loop_cnt hold indefinitely (one-shot cycles through the addresses exactly once).
REQ-027 RUN, tick=0: all state holds.
REQ-028 seq_end is high for exactly one cycle per terminal tick; back-to-back terminal ticks (last_addr=0, mode=1, tick held high) give a continuous high.
REQ-029 Latency: addr updates on the clock edge that samples tick; there is no pipeline stage.

Reset
REQ-030 rst=1 asynchronously forces addr=0, loop_cnt=0, seq_end=0, done=0.
REQ-031 During reset, state = RUN (busy=1) if AUTO_START=1, else IDLE (busy=0).
REQ-032 Reset asserted mid-operation discards all progress; after release the block behaves as after power-up.

Verification
REQ-033 N=3, AUTO_START=1, mode=0, last_addr=4, tick every cycle after reset release -> addr 0,1,2,3,4 then holds 4; seq_end pulses once; done=1 and busy=0 from the cycle after the terminal tick.
REQ-034 mode=1, last_addr=2, 9 ticks -> addr 0,1,2,0,1,2,0,1,2,0; loop_cnt=3; seq_end pulses 3 times.
REQ-035 In RUN at addr=3, start and tick in the same cycle -> addr=0, loop_cnt=0, busy=1; with abort also high -> IDLE, addr=3.
REQ-036 last_addr lowered from 6 to 1 while addr=4, mode=0 -> next tick gives DONE with addr=4; mode=1 -> next tick gives addr=0.
REQ-037 LW=2, mode=1, last_addr=0, 6 ticks -> loop_cnt saturates at 3 and seq_end stays high for 6 cycles.
REQ-038 rst asserted between clock edges in RUN at addr=2 -> addr=0 immediately, before the next edge; AUTO_START=0 -> IDLE and start required to run.
